// File: rtl/data_line_memory.sv
// data_line_memory
//   Backing-store responder on the memory side of the data cache. Serves
//   line refills (read) and line flushes (write-back) with a fixed access
//   latency so cache miss/flush timing behaves like real memory.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low
//   refill_request : level request for a line, held until refill_valid
//   refill_address : byte address of the requested line
//   refill_data    : returned line, held until the next refill completes
//   refill_valid   : one-cycle pulse, refill_data valid
//   flush_request  : level request to write back a line, held until flush_ack
//   flush_address  : byte address of the flushed line
//   flush_data     : line to store
//   flush_ack      : one-cycle pulse, line committed to the array
//   busy           : high whenever a transaction is in progress
module data_line_memory #(
    parameter int unsigned LINE_BITS   = 256,
    parameter int unsigned OFFSET_BITS = 5,
    parameter int unsigned DEPTH_LINES = 4096,
    parameter int unsigned LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 refill_request,
    input  logic [31:0]          refill_address,
    output logic [LINE_BITS-1:0] refill_data,
    output logic                 refill_valid,
    input  logic                 flush_request,
    input  logic [31:0]          flush_address,
    input  logic [LINE_BITS-1:0] flush_data,
    output logic                 flush_ack,
    output logic                 busy
);

    localparam int unsigned IDX_BITS = $clog2(DEPTH_LINES);
    localparam int unsigned CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RD,
        WAIT_WR,
        DONE
    } state_t;

    state_t                state;
    logic [CNT_BITS-1:0]   counter;
    logic [IDX_BITS-1:0]   lat_idx;
    logic [LINE_BITS-1:0]  lat_data;
    logic [LINE_BITS-1:0]  mem [DEPTH_LINES];
    logic                  cnt_zero;
    logic                  mem_we;
    logic                  unused_addr_bits;

    // Offset and above-index address bits are deliberately ignored.
    assign unused_addr_bits = ^{flush_address, refill_address};

    assign cnt_zero = (counter == '0);
    assign busy     = (state != IDLE);

    // Reset forces state to IDLE asynchronously, so an abandoned flush can
    // never reach the write below.
    assign mem_we = (state == WAIT_WR) && cnt_zero;

    // Array is not reset: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[lat_idx] <= lat_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= '0;
            lat_idx      <= '0;
            lat_data     <= '0;
            refill_data  <= '0;
            refill_valid <= 1'b0;
            flush_ack    <= 1'b0;
        end else begin
            refill_valid <= 1'b0;
            flush_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    // Flush wins so a same-line refill sees the written-back data.
                    if (flush_request) begin
                        lat_idx  <= flush_address[OFFSET_BITS +: IDX_BITS];
                        lat_data <= flush_data;
                        counter  <= CNT_LOAD;
                        state    <= WAIT_WR;
                    end else if (refill_request) begin
                        lat_idx  <= refill_address[OFFSET_BITS +: IDX_BITS];
                        counter  <= CNT_LOAD;
                        state    <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (cnt_zero) begin
                        refill_data  <= mem[lat_idx];
                        refill_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        counter <= counter - CNT_BITS'(1);
                    end
                end
                WAIT_WR: begin
                    if (cnt_zero) begin
                        flush_ack <= 1'b1;
                        state     <= DONE;
                    end else begin
                        counter <= counter - CNT_BITS'(1);
                    end
                end
                DONE: begin
                    // Requests ignored here so the level request can drop.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_line_memory.sv
// tb_data_line_memory
//   Self-checking bench for data_line_memory: directed scenarios followed
//   by randomized flush/refill traffic compared against a line-indexed
//   reference memory.
module tb_data_line_memory;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         refill_request;
    logic [31:0]  refill_address;
    logic [255:0] refill_data;
    logic         refill_valid;
    logic         flush_request;
    logic [31:0]  flush_address;
    logic [255:0] flush_data;
    logic         flush_ack;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Reference store: line index -> last committed line.
    logic [255:0] model [int];

    always #5 clk = ~clk;

    data_line_memory #(
        .LINE_BITS   (256),
        .OFFSET_BITS (5),
        .DEPTH_LINES (4096),
        .LATENCY     (L)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .refill_request (refill_request),
        .refill_address (refill_address),
        .refill_data    (refill_data),
        .refill_valid   (refill_valid),
        .flush_request  (flush_request),
        .flush_address  (flush_address),
        .flush_data     (flush_data),
        .flush_ack      (flush_ack),
        .busy           (busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32) % 4096);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction from an idle DUT: timing, pulse width, busy
    // window and (for refills of known lines) returned data.
    task automatic xact(input bit fl, input logic [31:0] a, input logic [255:0] d);
        int  n;
        bit  seen;
        logic [255:0] exp_line;
        bit  known;
        known    = model.exists(idx_of(a));
        exp_line = known ? model[idx_of(a)] : '0;
        if (fl) begin
            flush_request = 1'b1; flush_address = a; flush_data = d;
        end else begin
            refill_request = 1'b1; refill_address = a;
        end
        tick;
        // Inputs changed after acceptance must have no effect.
        if (fl) begin
            flush_data = ~d; flush_address = a ^ 32'h0000_0FE0;
        end else begin
            refill_address = a ^ 32'h0000_0FE0;
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            chk("busy_in_flight", busy, 1);
            tick; n++;
            seen = fl ? flush_ack : refill_valid;
        end
        chk("pulse_seen", seen, 1);
        chk("latency", n, L);
        chk("busy_at_pulse", busy, 1);
        chk("no_other_pulse", fl ? refill_valid : flush_ack, 0);
        if (fl) begin
            model[idx_of(a)] = d;
        end else if (known) begin
            chk("refill_data", refill_data, exp_line);
        end
        flush_request = 1'b0; refill_request = 1'b0;
        tick;
        chk("pulse_one_cycle", fl ? flush_ack : refill_valid, 0);
        chk("busy_cleared", busy, 0);
        if (!fl && known) chk("refill_hold", refill_data, exp_line);
    endtask

    initial begin
        int n;
        int pool [4] = '{32'h155, 32'h355, 32'h555, 32'h0A7};
        logic [31:0]  ra;
        logic [255:0] rd;
        bit rf;

        reset = 1'b0;
        refill_request = 1'b0; refill_address = '0;
        flush_request = 1'b0;  flush_address = '0; flush_data = '0;
        #23;
        chk("rst_valid", refill_valid, 0);
        chk("rst_ack", flush_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", refill_data, 0);
        reset = 1'b1;
        tick;

        // Reset in the middle of a refill.
        refill_request = 1'b1; refill_address = 32'h0000_1000;
        tick; tick;
        chk("pre_rst_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrd_valid", refill_valid, 0);
        chk("midrd_busy", busy, 0);
        chk("midrd_data", refill_data, 0);
        refill_request = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < L + 2; i++) begin
            tick;
            chk("post_rst_no_valid", refill_valid, 0);
            chk("post_rst_idle", busy, 0);
        end

        // Flush then refill with non-zero offset.
        xact(1'b1, 32'h0000_2AA0, 256'h12AD_BEEF);
        xact(1'b0, 32'h0000_2AA4, '0);
        chk("refill_2aa4", refill_data, 256'h12AD_BEEF);

        // Simultaneous requests: flush first, refill after DONE.
        flush_request = 1'b1; flush_address = 32'h0000_AAA0; flush_data = 256'hAAAA_1121;
        refill_request = 1'b1; refill_address = 32'h0000_AAA0;
        tick;
        n = 0;
        while (!flush_ack && n < 20) begin
            chk("prio_no_valid", refill_valid, 0);
            tick; n++;
        end
        chk("prio_ack_latency", n, L);
        chk("prio_ack", flush_ack, 1);
        model[idx_of(32'h0000_AAA0)] = 256'hAAAA_1121;
        flush_request = 1'b0; flush_data = '0;
        n = 0;
        while (!refill_valid && n < 30) begin
            tick; n++;
        end
        chk("prio_refill_latency", n, L + 2);
        chk("prio_refill_data", refill_data, 256'hAAAA_1121);
        chk("prio_no_second_ack", flush_ack, 0);
        refill_request = 1'b0;
        tick;
        chk("prio_idle", busy, 0);

        // Index wrap and a distinct index.
        xact(1'b1, 32'h0000_6AA0, 256'h5555_0355);
        xact(1'b0, 32'h0002_2AA0, '0);
        chk("wrap_155", refill_data, 256'h12AD_BEEF);
        xact(1'b0, 32'h0000_6AA0, '0);
        chk("distinct_355", refill_data, 256'h5555_0355);

        // Flush abandoned by reset in its second wait cycle.
        flush_request = 1'b1; flush_address = 32'h0000_2AA0; flush_data = 256'hCAFE_BABE;
        tick; tick;
        #2 reset = 1'b0;
        #1;
        chk("abort_ack", flush_ack, 0);
        chk("abort_busy", busy, 0);
        flush_request = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < L + 2; i++) begin
            tick;
            chk("abort_no_ack", flush_ack, 0);
        end
        xact(1'b0, 32'h0000_2AA0, '0);
        chk("abort_kept", refill_data, 256'h12AD_BEEF);

        // Randomized traffic over a small index pool.
        for (int i = 0; i < 40; i++) begin
            rf = $urandom_range(0, 1) == 1;
            ra = ($urandom() << 17) | (pool[$urandom_range(0, 3)] << 5) | $urandom_range(0, 31);
            rd = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            xact(rf, ra, rd);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
